// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor count, floor-number width, call FSM states
// and the floor-number to one-hot decoder used by the passenger panel.
package elevator_pkg;

  localparam int NUM_FLOORS = 5;
  localparam int FLOOR_W    = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    PENDING = 2'd2
  } call_state_t;

  // Floors are 1-based; 0 and anything above NUM_FLOORS decode to all zeros.
  function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] floor);
    logic [NUM_FLOORS-1:0] oh;
    oh = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (floor == FLOOR_W'(f + 1)) oh[f] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One push-button channel: 2-flop synchroniser, saturating press counter and a
// release flag so a held button qualifies exactly once per press.
module button_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic press_o
);

  localparam int            CW      = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] hi_cnt_q, hi_cnt_d;
  logic [CW-1:0] lo_cnt_q, lo_cnt_d;
  logic          rel_q, rel_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      hi_cnt_q <= '0;
      lo_cnt_q <= '0;
      rel_q    <= 1'b1;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      hi_cnt_q <= hi_cnt_d;
      lo_cnt_q <= lo_cnt_d;
      rel_q    <= rel_d;
    end
  end

  // press_o is a strobe for the edge on which hi_cnt reaches CNT_MAX.
  always_comb begin
    hi_cnt_d = hi_cnt_q;
    lo_cnt_d = lo_cnt_q;
    rel_d    = rel_q;
    press_o  = 1'b0;
    if (sync2_q) begin
      lo_cnt_d = '0;
      if (hi_cnt_q != CNT_MAX) hi_cnt_d = hi_cnt_q + 1'b1;
      if ((hi_cnt_q == CNT_MAX - 1'b1) && rel_q) begin
        press_o = 1'b1;
        rel_d   = 1'b0;
      end
    end else begin
      hi_cnt_d = '0;
      if (lo_cnt_q != CNT_MAX) lo_cnt_d = lo_cnt_q + 1'b1;
      if (lo_cnt_q == CNT_MAX - 1'b1) rel_d = 1'b1;
    end
  end

endmodule

// File: rtl/call_panel.sv
// Passenger call panel: debounced presses become one-cycle request pulses and
// latched call lamps cleared by car dwell. Optional re-pulse: CALL_PANEL_RESEND_EN.
module call_panel
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int DWELL_CYC    = 2
`ifdef CALL_PANEL_RESEND_EN
  , parameter int RESEND_PERIOD = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] raw_buttons,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  busy,
  output logic [NUM_FLOORS-1:0] buttons,
  output logic [NUM_FLOORS-1:0] lamps,
  output logic                  pending_any,
  output logic                  chime
);

  localparam int            DW        = $clog2(DWELL_CYC + 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_CYC);
  localparam logic [DW-1:0] DWELL_MIN = DW'(DWELL_CYC - 1);

  logic [NUM_FLOORS-1:0] press;
  logic [NUM_FLOORS-1:0] served;
  logic [NUM_FLOORS-1:0] send_v, lamp_v, lamp_next, clear_v;
  logic [FLOOR_W-1:0]    prev_floor_q;
  logic [DW-1:0]         dwell_cnt_q, dwell_cnt_d;
  logic                  stopped;
  logic                  pending_any_q, chime_q;

  call_state_t [NUM_FLOORS-1:0] state_q, state_d;

  for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
      .clk    (clk),
      .rst_n  (reset),
      .raw_i  (raw_buttons[f]),
      .press_o(press[f])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_floor_q <= '0;
      dwell_cnt_q  <= '0;
    end else begin
      prev_floor_q <= current_floor;
      dwell_cnt_q  <= dwell_cnt_d;
    end
  end

  // dwell_cnt_d already counts the current cycle, so a single-cycle pass-through reads 0.
  always_comb begin
    if (current_floor != prev_floor_q)  dwell_cnt_d = '0;
    else if (dwell_cnt_q == DWELL_MAX)  dwell_cnt_d = dwell_cnt_q;
    else                                dwell_cnt_d = dwell_cnt_q + 1'b1;
  end

  assign stopped = (dwell_cnt_d >= DWELL_MIN) || !busy;
  assign served  = floor_onehot(current_floor) & {NUM_FLOORS{stopped}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int f = 0; f < NUM_FLOORS; f++) state_q[f] <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A press served on arrival still pulses so the controller reopens the door.
  always_comb begin
    state_d = state_q;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      case (state_q[f])
        IDLE:    if (press[f]) state_d[f] = SEND;
        SEND:    state_d[f] = served[f] ? IDLE : PENDING;
        PENDING: if (served[f]) state_d[f] = IDLE;
        default: state_d[f] = IDLE;
      endcase
    end
  end

  always_comb begin
    send_v    = '0;
    lamp_v    = '0;
    lamp_next = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      send_v[f]    = (state_q[f] == SEND);
      lamp_v[f]    = (state_q[f] == PENDING);
      lamp_next[f] = (state_d[f] == PENDING);
    end
    clear_v = lamp_v & served;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_any_q <= 1'b0;
      chime_q       <= 1'b0;
    end else begin
      pending_any_q <= |lamp_next;
      chime_q       <= |clear_v;
    end
  end

`ifdef CALL_PANEL_RESEND_EN
  localparam int RW = (RESEND_PERIOD > 1) ? $clog2(RESEND_PERIOD) : 1;

  logic [RW-1:0] resend_cnt_q;
  logic          resend_wrap;

  assign resend_wrap = (resend_cnt_q == RW'(RESEND_PERIOD - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           resend_cnt_q <= '0;
    else if (resend_wrap) resend_cnt_q <= '0;
    else                  resend_cnt_q <= resend_cnt_q + 1'b1;
  end

  assign buttons = send_v | (lamp_v & {NUM_FLOORS{resend_wrap}});
`else
  assign buttons = send_v;
`endif

  assign lamps       = lamp_v;
  assign pending_any = pending_any_q;
  assign chime       = chime_q;

endmodule

// File: doc/call_panel.md
Name: call_panel

Overview:
- Passenger-side front end for the elevator controller.
- Synchronises and debounces raw floor push-buttons, then drives one-cycle request pulses onto the controller's 5-bit request input.
- Holds a call lamp per floor until the car is seen dwelling at that floor, recovering service status only from the controller's current_floor/busy outputs.

Parameters:
- NUM_FLOORS, 5, floor count; floors numbered 1..NUM_FLOORS on current_floor.
- DEBOUNCE_CYC, 4, consecutive synced-high cycles that qualify a press (>=1).
- DWELL_CYC, 2, consecutive cycles at an unchanged floor that count as a stop (>=2).
- RESEND_PERIOD, 16, cycles between re-pulses of pending calls (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- raw_buttons  in  NUM_FLOORS  asynchronous panel buttons, bit f = floor f+1.
- current_floor  in  3  car floor from controller, 1-based.
- busy  in  1  controller busy flag.
- buttons  out  NUM_FLOORS  request pulses to controller, bit f = floor f+1.
- lamps  out  NUM_FLOORS  call lamps, high while a call is pending.
- pending_any  out  1  OR of lamps.
- chime  out  1  one-cycle pulse when any lamp clears by service.

Behaviour:
- Reset (reset=0, async): every flop clears; buttons=0, lamps=0, pending_any=0, chime=0; all floor FSMs IDLE; dwell counter 0; prev_floor 0; release flags set. Reset mid-operation drops all pending calls; no pulse is emitted after release.
- Sync: each raw_buttons bit passes through a 2-flop synchroniser.
- Debounce:
  - Per-floor counter increments while the synced bit is 1 and saturates at DEBOUNCE_CYC; it clears when the synced bit is 0.
  - A press qualifies on the edge where the counter reaches DEBOUNCE_CYC and the floor's release flag is set. Qualifying clears the release flag.
  - The release flag sets again after the synced bit is 0 for DEBOUNCE_CYC consecutive cycles.
- Per-floor FSM:
  - IDLE -> SEND on a qualified press.
  - SEND: buttons[f]=1 for exactly one cycle, then PENDING.
  - PENDING: lamps[f]=1. Goes to IDLE when served[f]; chime pulses the same cycle lamps[f] falls.
  - Presses in SEND or PENDING are ignored.
- Latency: buttons[f] is high during the cycle after clock edge DEBOUNCE_CYC+2, counting the edge that first samples raw_buttons[f] high as edge 1 (default: after edge 6).
- Dwell detection:
  - prev_floor registers current_floor each cycle.
  - dwell_cnt clears when current_floor != prev_floor, otherwise increments, saturating at DWELL_CYC.
  - served[f] = (current_floor == f+1) && ((dwell_cnt >= DWELL_CYC-1) || !busy).
  - current_floor of 0 or above NUM_FLOORS serves nothing.
  - A pass-through floor (one cycle only) is not served.
- Simultaneous events:
  - Qualified press while served[f] already holds: SEND still pulses so the controller reopens the door, then the FSM returns to IDLE with no lamp and no chime.
  - Presses on several floors in one cycle: all pulse together in the same cycle.
  - Several lamps clearing in one cycle: a single chime pulse.
- pending_any is registered: it equals the OR of the lamps value in the same cycle, derived from next-state.

Optional Feature:
- Macro: CALL_PANEL_RESEND_EN.
- With the macro: a free-running counter wraps every RESEND_PERIOD cycles. On wrap, every floor in PENDING re-pulses buttons[f] for one cycle. This is idempotent at the controller (OR-latch).
- Without the macro: no counter; buttons pulses only from SEND.

Decomposition:
- Shared package elevator_pkg holds:
  - NUM_FLOORS and FLOOR_W=3.
  - Enum call_state_t {IDLE, SEND, PENDING}.
  - Function floor_onehot(floor) returning NUM_FLOORS bits, zero for out-of-range floors.
- One sub-module, button_debounce (synchroniser + counter + release flag, one per floor), instantiated NUM_FLOORS times by generate.
- Dwell logic and FSMs stay in call_panel.

Test Plan:
- Reset, current_floor=1, busy=0; raw_buttons[2] high 10 cycles -> buttons[2] high for exactly the cycle after edge 6; lamps=00100 from the next cycle; pending_any=1.
- Glitch: raw_buttons[0] high 3 cycles then low -> buttons and lamps stay 0.
- Pending floor 3, current_floor steps 1,2 (1 cycle each) then holds 3 for 2 cycles with busy=1 -> lamps[2] clears on the second cycle at floor 3; chime one pulse. Passing floor 3 for a single cycle leaves the lamp lit.
- Floor 4 pending, button held continuously -> no second pulse until released for 4 cycles and pressed again.
- Car idle at floor 2 (busy=0), press floor 2 -> one buttons[1] pulse; lamps[1] never rises; chime stays 0.
- Assert reset for one cycle while floors 1 and 5 pending -> lamps=0 immediately, no later pulses. With CALL_PANEL_RESEND_EN: a pending floor re-pulses every 16 cycles.
